// File: rtl/mult16_pkg.sv
// Shared constants and types for the 16x16 sequential multiplier controller.
`default_nettype none

package mult16_pkg;

   localparam int OP_W  = 16;
   localparam int RES_W = 32;

   localparam logic [1:0] STEP_LAST = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Steps 1 and 2 are the cross terms and share the same weight.
   function automatic logic [4:0] step_shift(input logic [1:0] step);
      case (step)
         2'd0:    step_shift = 5'd0;
         2'd3:    step_shift = 5'd16;
         default: step_shift = 5'd8;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi8bit.sv
// 8x8 unsigned combinational multiplier shared by the sequential controller.
`default_nettype none

module multi8bit (
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] p
);

   assign p = x * y;

endmodule

`default_nettype wire

// File: rtl/mult16_seq_ctrl.sv
// 16x16 multiplier time-sharing one 8x8 multiplier over four cycles.
// Optional MULT16_SIGNED_EN adds a signed_op port for two's-complement operands.
`default_nettype none

module mult16_seq_ctrl
   import mult16_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] product,
   output logic             busy
`ifdef MULT16_SIGNED_EN
   ,
   input  logic             signed_op
`endif
);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        step;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic              neg;
   logic [RES_W-1:0]  acc;
   logic [RES_W-1:0]  product_r;

   logic [OP_W-1:0]   a_mag;
   logic [OP_W-1:0]   b_mag;
   logic              neg_in;
   logic [7:0]        a_byte;
   logic [7:0]        b_byte;
   logic [15:0]       pp;
   logic [RES_W-1:0]  pp_shifted;
   logic [RES_W-1:0]  sum;

`ifdef MULT16_SIGNED_EN
   // Two's-complement negation of 0x8000 yields 0x8000, which is its magnitude.
   assign a_mag  = (signed_op && a[OP_W-1]) ? (~a + 16'd1) : a;
   assign b_mag  = (signed_op && b[OP_W-1]) ? (~b + 16'd1) : b;
   assign neg_in = signed_op && (a[OP_W-1] ^ b[OP_W-1]);
`else
   assign a_mag  = a;
   assign b_mag  = b;
   assign neg_in = 1'b0;
`endif

   // step[0] picks the high byte of a, step[1] the high byte of b.
   assign a_byte = step[0] ? op_a[15:8] : op_a[7:0];
   assign b_byte = step[1] ? op_b[15:8] : op_b[7:0];

   multi8bit u_mul (
      .x (a_byte),
      .y (b_byte),
      .p (pp)
   );

   assign pp_shifted = {16'd0, pp} << step_shift(step);
   assign sum        = acc + pp_shifted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)          state_nxt = MUL;
         MUL:     if (step == STEP_LAST) state_nxt = DONE;
         DONE:    if (out_ready)         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step      <= 2'd0;
         op_a      <= '0;
         op_b      <= '0;
         neg       <= 1'b0;
         acc       <= '0;
         product_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a <= a_mag;
                  op_b <= b_mag;
                  neg  <= neg_in;
                  acc  <= '0;
                  step <= 2'd0;
               end
            end
            MUL: begin
               acc  <= sum;
               step <= step + 2'd1;
               if (step == STEP_LAST) begin
                  product_r <= neg ? (~sum + 32'd1) : sum;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign product   = product_r;

endmodule

`default_nettype wire

// File: tb/tb_mult16_seq_ctrl.sv
// Self-checking bench for mult16_seq_ctrl: vector table, scoreboard, corner sequences.
`default_nettype none

module tb_mult16_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] product;
   logic        busy;
   logic        signed_op = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [31:0] sb[$];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sop;
      logic [31:0] exp;
      int          hold;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mult16_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
`ifdef MULT16_SIGNED_EN
      ,
      .signed_op (signed_op)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic sop,
                         input logic [31:0] exp, input int hold);
      int edges;
      logic [31:0] held;
      @(negedge clk);
      chk("in_ready_before_issue", 32'(in_ready), 32'd1);
      a = va; b = vb; signed_op = sop; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      sb.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'h5A5A; b = 16'hA5A5; signed_op = ~sop;
      edges = 0;
      while (!out_valid && edges < 12) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      chk("latency_edges", 32'(edges), 32'd4);
      held = product;
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         chk("bp_product_stable", product, held);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      end else begin
         chk("product", product, sb.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      chk("post_hs_busy", 32'(busy), 32'd0);
      chk("idle_product_held", product, exp);
      if (hold > 0) begin
         repeat (3) @(negedge clk);
         chk("bp_pulse_not_accepted", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int edges;
      int ov_edge;
      logic [15:0] ra;
      logic [15:0] rb;

      vecs.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F, 0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0});
      vecs.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000, 0});
      vecs.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060, 3});
      vecs.push_back('{16'h00FF, 16'hFF00, 1'b0, 32'h00FE0100, 0});
      vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 32'h00000000, 0});
      vecs.push_back('{16'hABCD, 16'h0001, 1'b0, 32'h0000ABCD, 0});
`ifdef MULT16_SIGNED_EN
      vecs.push_back('{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 0});
      vecs.push_back('{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 0});
      vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000, 0});
      vecs.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 0});
      vecs.push_back('{16'h0000, 16'hFFFF, 1'b1, 32'h00000000, 0});
`endif

      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_product", product, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sop, vecs[i].exp, vecs[i].hold);
      end

      for (int r = 0; r < 6; r++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(ra, rb, 1'b0, 32'(ra) * 32'(rb), 0);
      end

      // Back-to-back issue with out_ready tied high: accept every 6 edges.
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; a = 16'h0007; b = 16'h0009; signed_op = 1'b0;
      @(posedge clk);
      sb.push_back(32'd63);
      @(negedge clk);
      a = 16'h0002; b = 16'h0003;
      edges = 0;
      ov_edge = 0;
      while (!in_ready && edges < 12) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         if (out_valid && ov_edge == 0) begin
            ov_edge = edges;
            if (sb.size() != 0) chk("b2b_product", product, sb.pop_front());
         end
      end
      chk("b2b_out_valid_edge", 32'(ov_edge), 32'd4);
      chk("b2b_reissue_ready_edge", 32'(edges), 32'd5);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_second_accepted", 32'(busy), 32'd1);
      repeat (5) @(negedge clk);
      chk("b2b_second_product", product, 32'd6);
      out_ready = 1'b0;

      // Abort mid-MUL at step 2.
      @(negedge clk);
      a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_product", product, 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ov_edge = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) ov_edge = 1;
      end
      chk("abort_no_out_valid", 32'(ov_edge), 32'd0);
      run_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/mult16_seq_ctrl.md
MULT16_SEQ_CTRL -- requirements
Module: mult16_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, operand pair offered.
REQ-004 SHALL have port in_ready, output, 1, block can accept operands.
REQ-005 SHALL have port a, input, 16, multiplicand.
REQ-006 SHALL have port b, input, 16, multiplier.
REQ-007 SHALL have port out_valid, output, 1, product available.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-009 SHALL have port product, output, 32, result a*b.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL compute a 16x16 product by time-sharing one 8x8 unsigned combinational multiplier over 4 cycles.
REQ-012 SHALL implement states IDLE, MUL, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; in_valid is ignored in MUL and DONE.
REQ-014 SHALL, on in_valid&&in_ready, register a and b, clear the 32-bit accumulator, set step=0, and go to MUL.
REQ-015 SHALL in MUL add one partial product per cycle: step0 aL*bL<<0, step1 aH*bL<<8, step2 aL*bH<<8, step3 aH*bH<<16.
REQ-016 SHALL advance from MUL to DONE after step3; the accumulator is 32 bits and never overflows.
REQ-017 SHALL assert out_valid exactly 4 clock edges after the accepting edge.
REQ-018 SHALL, in DONE, hold out_valid and product stable until out_ready=1, then return to IDLE on that edge.
REQ-019 SHALL keep product equal to the last completed result while in IDLE.
REQ-020 SHALL give minimum issue interval 6 cycles with out_ready tied high; the new accept edge occurs one cycle after the output handshake.

Reset
REQ-021 SHALL on rst_n low immediately force: state=IDLE, step=0, accumulator=0, product=0, out_valid=0, busy=0, in_ready=1.
REQ-022 SHALL discard any in-flight operation on reset mid-MUL or mid-DONE; no partial result is ever presented.

Configuration
REQ-023 SHALL, with MULT16_SIGNED_EN defined, add input port signed_op (1 bit, sampled at accept); when signed_op=1, operands are two's complement and the block multiplies magnitudes and negates the result if the signs differ; 0x8000 magnitude is 0x8000.
REQ-024 SHALL, without MULT16_SIGNED_EN, have no signed_op port and treat all operands as unsigned; latency is identical in both builds.

Structure
REQ-025 SHALL place state encodings (IDLE/MUL/DONE), STEP_LAST=3, and width constants (OP_W=16, RES_W=32) in shared package mult16_pkg.
REQ-026 SHALL instantiate the existing 8x8 multiplier multi8bit as its single sub-module; the controller contains only the mux, shift, accumulate, and FSM logic.

Verification
REQ-027 Reset: rst_n low mid-stream -> out_valid=0, product=0, in_ready=1, busy=0 asynchronously.
REQ-028 Basic: a=0x0003, b=0x0005 accepted at edge N -> out_valid high after edge N+4, product=0x0000000F.
REQ-029 Corner: a=0xFFFF, b=0xFFFF unsigned -> product=0xFFFE0001; a=0x8000, b=0x0002 -> 0x00010000.
REQ-030 Backpressure: out_ready low 3 cycles in DONE -> product and out_valid stable, in_ready=0, a concurrently offered in_valid pulse not accepted.
REQ-031 Abort: rst_n pulsed at step2 of a=0x1234, b=0x5678 -> IDLE, no out_valid; a re-issued op yields 0x06260060.
REQ-032 Signed (MULT16_SIGNED_EN): a=0xFFFF, b=0x0002, signed_op=1 -> 0xFFFFFFFE; same operands with signed_op=0 -> 0x0001FFFE.
